// File: rtl/mult_share_sched.sv
// rtl/mult_share_sched.sv - round-robin scheduler sharing one clock-gated multiplier
//
// Purpose:
//    Arbitrates NREQ requesters onto a single registered 16x16 multiplier.
//    The winning operands are registered onto mul_a/mul_b and mul_en is raised
//    only on cycles carrying a real operation, so the multiplier clock stays
//    gated when idle. Each issued operation is tagged with its requester ID and
//    the product is returned with that ID once the multiplier latency elapses.
//    Saturating active/gated cycle counters support power evaluation.
//
// Ports:
//    clk         system clock, rising edge
//    rst         asynchronous reset, active low
//    cfg_enable  1 = grants allowed, 0 = no new grants (in-flight ops drain)
//    cnt_clr     synchronous clear of both statistics counters
//    req_valid   per-requester request
//    req_a/req_b packed operands, slice i belongs to requester i
//    req_ready   one-hot grant (combinational)
//    mul_en      multiplier enable / clock-gate control
//    mul_a/mul_b multiplier operands
//    mul_y       multiplier product (registered inside the multiplier)
//    rsp_valid   one-cycle pulse per returned product
//    rsp_id      requester index of the returned product
//    rsp_y       returned product
//    busy        an operation is in flight
//    active_cnt  cycles with mul_en = 1 (saturating)
//    gated_cnt   cycles with mul_en = 0 (saturating)

module mult_share_sched #(
   parameter int NREQ    = 4,
   parameter int IDW     = 2,
   parameter int MUL_LAT = 1,
   parameter int CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_enable,
   input  logic                 cnt_clr,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*16-1:0]   req_a,
   input  logic [NREQ*16-1:0]   req_b,
   output logic [NREQ-1:0]      req_ready,
   output logic                 mul_en,
   output logic [15:0]          mul_a,
   output logic [15:0]          mul_b,
   input  logic [31:0]          mul_y,
   output logic                 rsp_valid,
   output logic [IDW-1:0]       rsp_id,
   output logic [31:0]          rsp_y,
   output logic                 busy,
   output logic [CNT_W-1:0]     active_cnt,
   output logic [CNT_W-1:0]     gated_cnt
);

   logic [IDW-1:0]   ptr_q, ptr_d;
   logic             mul_en_q;
   logic [15:0]      mul_a_q, mul_b_q, sel_a, sel_b;
   logic [MUL_LAT:0] pipe_v_q;
   logic [IDW-1:0]   pipe_id_q [MUL_LAT+1];
   logic             rsp_valid_q;
   logic [IDW-1:0]   rsp_id_q;
   logic [31:0]      rsp_y_q;
   logic [CNT_W-1:0] act_q, act_d, gat_q, gat_d;

   logic [NREQ-1:0]  req_m, req_hi;
   logic             found, found_hi, hs;
   logic [IDW-1:0]   gnt_idx;

   // Round-robin pick: the lowest requester above the pointer wins; if none
   // is above it, wrap around to the lowest requester overall. Grants are
   // forced off while reset is asserted so every output reads 0 in reset.
   always_comb begin
      req_m    = (cfg_enable && rst) ? req_valid : '0;
      found    = 1'b0;
      found_hi = 1'b0;
      gnt_idx  = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_hi[i] = req_m[i] && (i > int'(ptr_q));
      end
      for (int i = NREQ-1; i >= 0; i--) begin
         if (req_m[i]) begin
            found   = 1'b1;
            gnt_idx = IDW'(i);
         end
      end
      for (int i = NREQ-1; i >= 0; i--) begin
         if (req_hi[i]) begin
            found_hi = 1'b1;
            gnt_idx  = IDW'(i);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         req_ready[i] = found && (gnt_idx == IDW'(i));
      end
   end

   // A grant is only ever given to a valid requester, so any grant is a handshake.
   assign hs = found;

   always_comb begin
      sel_a = mul_a_q;
      sel_b = mul_b_q;
      for (int i = 0; i < NREQ; i++) begin
         if (req_ready[i]) begin
            sel_a = req_a[i*16 +: 16];
            sel_b = req_b[i*16 +: 16];
         end
      end
   end

   always_comb begin
      ptr_d = hs ? gnt_idx : ptr_q;
      act_d = act_q;
      gat_d = gat_q;
      if (cnt_clr) begin
         act_d = '0;
         gat_d = '0;
      end else if (mul_en_q) begin
         if (act_q != '1) act_d = act_q + CNT_W'(1);
      end else begin
         if (gat_q != '1) gat_d = gat_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q       <= IDW'(NREQ-1);
         mul_en_q    <= 1'b0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         pipe_v_q    <= '0;
         for (int k = 0; k <= MUL_LAT; k++) pipe_id_q[k] <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_y_q     <= '0;
         act_q       <= '0;
         gat_q       <= '0;
      end else begin
         ptr_q    <= ptr_d;
         mul_en_q <= hs;
         // Operands only move on a handshake so the gated multiplier sees no toggling.
         mul_a_q  <= sel_a;
         mul_b_q  <= sel_b;
         // Stage k holds the tag of the op handshaken k edges ago; the last
         // stage lines up with the cycle in which mul_y carries its product.
         pipe_v_q[0]  <= hs;
         pipe_id_q[0] <= gnt_idx;
         for (int k = 1; k <= MUL_LAT; k++) begin
            pipe_v_q[k]  <= pipe_v_q[k-1];
            pipe_id_q[k] <= pipe_id_q[k-1];
         end
         rsp_valid_q <= pipe_v_q[MUL_LAT];
         if (pipe_v_q[MUL_LAT]) begin
            rsp_y_q  <= mul_y;
            rsp_id_q <= pipe_id_q[MUL_LAT];
         end
         act_q <= act_d;
         gat_q <= gat_d;
      end
   end

   assign mul_en     = mul_en_q;
   assign mul_a      = mul_a_q;
   assign mul_b      = mul_b_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_y      = rsp_y_q;
   // The response register is the final pipeline stage, so busy drops only
   // once the last rsp_valid pulse has been presented.
   assign busy       = mul_en_q | (|pipe_v_q) | rsp_valid_q;
   assign active_cnt = act_q;
   assign gated_cnt  = gat_q;

endmodule

// File: tb/tb_mult_share_sched.sv
// tb/tb_mult_share_sched.sv - scoreboard bench for mult_share_sched

module tb_mult_share_sched;

   localparam int NREQ    = 4;
   localparam int IDW     = 2;
   localparam int MUL_LAT = 1;
   localparam int CNT_W   = 4;
   localparam int CMAX    = (1 << CNT_W) - 1;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                cfg_enable = 1'b0;
   logic                cnt_clr = 1'b0;
   logic [NREQ-1:0]     req_valid = '0;
   logic [NREQ*16-1:0]  req_a = '0;
   logic [NREQ*16-1:0]  req_b = '0;
   logic [NREQ-1:0]     req_ready;
   logic                mul_en;
   logic [15:0]         mul_a, mul_b;
   logic [31:0]         mul_y;
   logic                rsp_valid;
   logic [IDW-1:0]      rsp_id;
   logic [31:0]         rsp_y;
   logic                busy;
   logic [CNT_W-1:0]    active_cnt, gated_cnt;

   mult_share_sched #(.NREQ(NREQ), .IDW(IDW), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cnt_clr(cnt_clr),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
      .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y), .busy(busy),
      .active_cnt(active_cnt), .gated_cnt(gated_cnt)
   );

   always #5 clk = ~clk;

   // Behavioural clock-gated multiplier with registered output.
   always @(posedge clk) if (mul_en) mul_y <= {16'b0, mul_a} * {16'b0, mul_b};

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   typedef struct {
      logic [IDW-1:0] id;
      logic [31:0]    y;
      int             due;
   } exp_t;
   exp_t sb[$];

   // Reference model: round robin by "last granted index", issue registers,
   // saturating counters. Pushes one expected response per predicted grant.
   int          last_g = NREQ-1;
   int          g;
   logic        exp_en = 1'b0;
   logic [15:0] exp_a = '0, exp_b = '0;
   int          exp_act = 0, exp_gat = 0;

   always @(negedge clk) begin
      if (!rst) begin
         last_g = NREQ-1; exp_en = 1'b0; exp_a = '0; exp_b = '0;
         exp_act = 0; exp_gat = 0;
         sb.delete();
      end else begin
         check("active_cnt", active_cnt, exp_act);
         check("gated_cnt", gated_cnt, exp_gat);
         check("mul_en", mul_en, exp_en);
         check("mul_a", mul_a, exp_a);
         check("mul_b", mul_b, exp_b);
         if (cnt_clr) begin
            exp_act = 0; exp_gat = 0;
         end else if (exp_en) begin
            if (exp_act < CMAX) exp_act++;
         end else begin
            if (exp_gat < CMAX) exp_gat++;
         end
         g = -1;
         if (cfg_enable) begin
            for (int k = 1; k <= NREQ; k++) begin
               if (g < 0 && req_valid[(last_g + k) % NREQ]) g = (last_g + k) % NREQ;
            end
         end
         check("req_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
         exp_en = (g >= 0);
         if (g >= 0) begin
            last_g = g;
            exp_a = req_a[g*16 +: 16];
            exp_b = req_b[g*16 +: 16];
            sb.push_back('{id: IDW'(g), y: {16'b0, exp_a} * {16'b0, exp_b},
                           due: cyc + MUL_LAT + 2});
         end
      end
   end

   // Response monitor: pops and compares whenever the DUT presents a product.
   logic [31:0]    last_y = '0;
   logic [IDW-1:0] last_id = '0;
   exp_t           e;

   always @(negedge clk) begin
      if (!rst) begin
         last_y = '0; last_id = '0;
      end else if (rsp_valid) begin
         if (sb.size() == 0) begin
            check("rsp_unexpected", rsp_valid, 0);
         end else begin
            e = sb.pop_front();
            check("rsp_id", rsp_id, e.id);
            check("rsp_y", rsp_y, e.y);
            check("rsp_cycle", cyc, e.due);
            last_y = e.y; last_id = e.id;
         end
      end else begin
         check("rsp_y_hold", rsp_y, last_y);
         check("rsp_id_hold", rsp_id, last_id);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      step(2);
      check("rst_req_ready", req_ready, 0);
      check("rst_mul_en", mul_en, 0);
      check("rst_mul_a", mul_a, 0);
      check("rst_mul_b", mul_b, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_rsp_y", rsp_y, 0);
      check("rst_busy", busy, 0);
      check("rst_active_cnt", active_cnt, 0);
      check("rst_gated_cnt", gated_cnt, 0);
      rst = 1'b1;
      cfg_enable = 1'b1;
      step(1);

      // single request from requester 2
      req_a[2*16 +: 16] = 16'd20;
      req_b[2*16 +: 16] = 16'd10;
      req_valid = 4'b0100;
      step(1);
      req_valid = '0;
      check("busy_inflight", busy, 1);
      step(5);
      check("busy_drained", busy, 0);

      // all four requesting continuously
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*16 +: 16] = 16'(100 + i);
         req_b[i*16 +: 16] = 16'd25;
      end
      req_valid = '1;
      step(8);
      req_valid = '0;
      step(4);

      // idle gap: operands must hold while gated
      step(10);

      // disabled with requester 1 holding max operands, then re-enable
      cfg_enable = 1'b0;
      req_a[1*16 +: 16] = 16'hFFFF;
      req_b[1*16 +: 16] = 16'hFFFF;
      req_valid = 4'b0010;
      step(5);
      cfg_enable = 1'b1;
      step(1);
      req_valid = '0;
      step(4);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         req_valid  = NREQ'($urandom);
         req_a      = {$urandom, $urandom};
         req_b      = {$urandom, $urandom};
         cfg_enable = ($urandom % 8) != 0;
         cnt_clr    = ($urandom % 16) == 0;
         step(1);
      end
      req_valid = '0;
      cfg_enable = 1'b1;
      cnt_clr = 1'b0;
      step(5);

      // reset with two operations in flight
      req_a = {$urandom, $urandom};
      req_b = {$urandom, $urandom};
      req_valid = '1;
      step(2);
      rst = 1'b0;
      #1;
      check("arst_mul_en", mul_en, 0);
      check("arst_req_ready", req_ready, 0);
      check("arst_rsp_valid", rsp_valid, 0);
      check("arst_busy", busy, 0);
      check("arst_mul_a", mul_a, 0);
      check("arst_active_cnt", active_cnt, 0);
      req_valid = 4'b1001;
      step(1);
      rst = 1'b1;
      #1;
      check("post_rst_grant", req_ready, 4'b0001);
      step(1);
      req_valid = '0;
      step(6);

      // counter saturation and clear-with-priority
      cnt_clr = 1'b1;
      step(1);
      cnt_clr = 1'b0;
      step(20);
      check("gated_sat", gated_cnt, CMAX);
      check("active_after_idle", active_cnt, 0);
      req_valid = 4'b0001;
      step(1);
      cnt_clr = 1'b1;
      step(1);
      cnt_clr = 1'b0;
      check("clr_active", active_cnt, 0);
      check("clr_gated", gated_cnt, 0);
      req_valid = '0;
      step(6);

      check("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
